// File: rtl/uart_reverse_echo_ctrl.sv
// Reverse-echo sequencer between uart_rx and uart_tx: stacks received bytes in a LIFO,
// then drains them newest-first through uart_tx with a DV/Done handshake.
module uart_reverse_echo_ctrl #(
  parameter int         DEPTH      = 4,
  parameter logic [7:0] TERMINATOR = 8'h0D,
  parameter bit         USE_TERM   = 1'b1,
  localparam int        CW         = $clog2(DEPTH + 1)
) (
  input  logic          hwclk,
  input  logic          rst_n,
  input  logic          rx_dv,
  input  logic [7:0]    rx_byte,
  input  logic          tx_active,
  input  logic          tx_done,
  output logic          tx_dv,
  output logic [7:0]    tx_byte,
  output logic          busy,
  output logic          rx_drop,
  output logic [CW-1:0] count
);

  typedef enum logic [1:0] {ST_COLLECT, ST_SEND, ST_WAIT} state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          tx_dv_q, tx_dv_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          rx_drop_q, rx_drop_d;
  logic          wr_en;
  logic [CW-1:0] rd_idx;

  // Sized to the full index range so any count value is a legal address.
  logic [7:0] mem_q [0:(2**CW)-1];

  assign rd_idx = count_q - 1'b1;

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_COLLECT;
      count_q   <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      rx_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      rx_drop_q <= rx_drop_d;
    end
  end

  // Storage is data only; its contents after reset are irrelevant.
  always_ff @(posedge hwclk) begin
    if (wr_en) begin
      mem_q[count_q] <= rx_byte;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    rx_drop_d = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (rx_dv) begin
          if (USE_TERM && (rx_byte == TERMINATOR)) begin
            if (count_q != '0) begin
              state_d = ST_SEND;
            end
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
            if (count_d == DEPTH_C) begin
              state_d = ST_SEND;
            end
          end
        end
      end
      ST_SEND: begin
        rx_drop_d = rx_dv;
        // tx_byte is only reloaded while the transmitter is idle.
        if (!tx_active) begin
          tx_byte_d = mem_q[rd_idx];
          tx_dv_d   = 1'b1;
          count_d   = rd_idx;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        rx_drop_d = rx_dv;
        if (tx_done) begin
          state_d = (count_q == '0) ? ST_COLLECT : ST_SEND;
        end
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  assign tx_dv   = tx_dv_q;
  assign tx_byte = tx_byte_q;
  assign busy    = (state_q == ST_SEND) || (state_q == ST_WAIT);
  assign rx_drop = rx_drop_q;
  assign count   = count_q;

endmodule

// File: tb/tb_uart_reverse_echo_ctrl.sv
// Scoreboard bench for uart_reverse_echo_ctrl with a behavioural uart_tx model.
module tb_uart_reverse_echo_ctrl;

  localparam int DEPTH = 4;
  localparam int TXLEN = 10;

  logic       hwclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       model_active = 1'b0;
  logic       hold_active = 1'b0;
  logic       tx_done = 1'b0;
  wire        tx_active_w = model_active | hold_active;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       busy;
  logic       rx_drop;
  logic [2:0] count;

  int n_cmp = 0;
  int n_err = 0;
  int dv_cnt = 0;
  int drop_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] stk[$];

  uart_reverse_echo_ctrl #(.DEPTH(DEPTH), .TERMINATOR(8'h0D), .USE_TERM(1'b1)) dut (
    .hwclk    (hwclk),
    .rst_n    (rst_n),
    .rx_dv    (rx_dv),
    .rx_byte  (rx_byte),
    .tx_active(tx_active_w),
    .tx_done  (tx_done),
    .tx_dv    (tx_dv),
    .tx_byte  (tx_byte),
    .busy     (busy),
    .rx_drop  (rx_drop),
    .count    (count)
  );

  always #5 hwclk = ~hwclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Output monitor: every DV pulse must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge hwclk);
      if (rx_drop === 1'b1) drop_cnt++;
      if (tx_dv === 1'b1) begin
        dv_cnt++;
        chk("tx_expected_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
      end
    end
  end

  // uart_tx model: busy for TXLEN cycles after DV, then a one-cycle Done.
  initial begin
    forever begin
      @(negedge hwclk);
      if (tx_dv === 1'b1 && rst_n) begin
        model_active = 1'b1;
        for (int i = 0; i < TXLEN; i++) begin
          @(negedge hwclk);
          if (!rst_n) break;
        end
        model_active = 1'b0;
        if (rst_n) begin
          tx_done = 1'b1;
          @(negedge hwclk);
          tx_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send_rx(input logic [7:0] b);
    @(negedge hwclk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge hwclk);
    rx_dv   = 1'b0;
  endtask

  task automatic flush_stack();
    while (stk.size() > 0) exp_q.push_back(stk.pop_back());
  endtask

  task automatic rx_data(input logic [7:0] b);
    send_rx(b);
    stk.push_back(b);
    if (stk.size() == DEPTH) flush_stack();
  endtask

  task automatic rx_term();
    send_rx(8'h0D);
    if (stk.size() > 0) flush_stack();
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 600; i++) begin
      @(negedge hwclk);
      if (!busy) break;
    end
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
  endtask

  initial begin
    int dv0;
    int drop0;

    repeat (3) @(negedge hwclk);
    chk("rst_tx_dv", 32'(tx_dv), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_drop", 32'(rx_drop), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge hwclk);

    // Full LIFO drains in reverse order.
    dv0 = dv_cnt;
    rx_data("A");
    chk("fill_count1", 32'(count), 32'd1);
    rx_data("B");
    rx_data("C");
    rx_data("D");
    chk("fill_busy", 32'(busy), 32'd1);
    wait_drain("abcd");
    chk("abcd_dv_pulses", 32'(dv_cnt - dv0), 32'd4);

    // Terminator ends the message early and is never echoed.
    dv0 = dv_cnt;
    rx_data("x");
    rx_data("y");
    rx_term();
    wait_drain("xy");
    chk("xy_dv_pulses", 32'(dv_cnt - dv0), 32'd2);

    // Lone terminator on an empty LIFO does nothing.
    dv0 = dv_cnt;
    drop0 = drop_cnt;
    rx_term();
    repeat (20) @(negedge hwclk);
    chk("lone_busy", 32'(busy), 32'd0);
    chk("lone_dv", 32'(dv_cnt - dv0), 32'd0);
    chk("lone_drop", 32'(drop_cnt - drop0), 32'd0);
    chk("lone_count", 32'(count), 32'd0);

    // A byte arriving mid-drain is dropped.
    dv0 = dv_cnt;
    drop0 = drop_cnt;
    rx_data("A");
    rx_data("B");
    rx_data("C");
    rx_data("D");
    for (int i = 0; i < 200; i++) begin
      if (dv_cnt > dv0) break;
      @(negedge hwclk);
    end
    chk("drop_reached_wait", 32'(dv_cnt > dv0), 32'd1);
    send_rx("Z");
    wait_drain("drop");
    chk("drop_pulses", 32'(drop_cnt - drop0), 32'd1);
    chk("drop_dv_pulses", 32'(dv_cnt - dv0), 32'd4);

    // Transmitter held busy: no DV until it frees up.
    dv0 = dv_cnt;
    hold_active = 1'b1;
    rx_data("E");
    rx_data("F");
    rx_data("G");
    rx_data("H");
    repeat (50) @(negedge hwclk);
    chk("hold_no_dv", 32'(dv_cnt - dv0), 32'd0);
    chk("hold_busy", 32'(busy), 32'd1);
    hold_active = 1'b0;
    @(negedge hwclk);
    chk("hold_dv_after", 32'(tx_dv), 32'd1);
    chk("hold_tx_byte", 32'(tx_byte), 32'h48);
    wait_drain("hold");
    chk("hold_dv_pulses", 32'(dv_cnt - dv0), 32'd4);

    // Reset in the middle of a drain.
    dv0 = dv_cnt;
    rx_data("A");
    rx_data("B");
    rx_data("C");
    rx_data("D");
    for (int i = 0; i < 200; i++) begin
      if (dv_cnt - dv0 >= 2) break;
      @(negedge hwclk);
    end
    chk("rst_mid_two_sent", 32'(dv_cnt - dv0), 32'd2);
    repeat (2) @(negedge hwclk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx_dv", 32'(tx_dv), 32'd0);
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    exp_q.delete();
    stk.delete();
    repeat (3) @(negedge hwclk);
    rst_n = 1'b1;
    repeat (2) @(negedge hwclk);
    dv0 = dv_cnt;
    rx_data("Q");
    rx_data("R");
    rx_data("S");
    rx_data("T");
    wait_drain("qrst");
    chk("qrst_dv_pulses", 32'(dv_cnt - dv0), 32'd4);

    repeat (5) @(negedge hwclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_reverse_echo_ctrl.md
# uart_reverse_echo_ctrl

Controller that sequences the shared `uart_rx`/`uart_tx` pair for the reverse-echo function. It collects received bytes into an internal LIFO. When the LIFO fills, or a terminator byte arrives, it drains the LIFO through `uart_tx` one byte at a time using a proper DV/Done handshake. It sits in `top` between the `uart_rx` outputs and the `uart_tx` inputs and replaces ad-hoc index logic with a single clocked FSM.

## Interface
- `DEPTH`, 4: LIFO capacity in bytes; legal range 2..255.
- `TERMINATOR`, 8'h0D: byte value that ends a message early.
- `USE_TERM`, 1: 1 = terminator detection enabled; 0 = every byte is data.
- `hwclk` in 1: system clock (12 MHz); all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_dv` in 1: one-cycle strobe from `uart_rx` `o_Rx_DV`.
- `rx_byte` in 8: `uart_rx` `o_Rx_Byte`; valid when `rx_dv`=1.
- `tx_active` in 1: `uart_tx` `o_Tx_Active`.
- `tx_done` in 1: `uart_tx` `o_Tx_Done`, a one-cycle pulse.
- `tx_dv` out 1: to `uart_tx` `i_Tx_DV`; registered one-cycle pulse.
- `tx_byte` out 8: to `uart_tx` `i_Tx_Byte`; registered.
- `busy` out 1: 1 while in SEND or WAIT.
- `rx_drop` out 1: one-cycle pulse when a received byte is discarded.
- `count` out clog2(DEPTH+1): bytes currently held in the LIFO.

## Operation
- Reset state (async, `rst_n`=0): state=COLLECT; `tx_dv`=0; `tx_byte`=8'h00; `busy`=0; `rx_drop`=0; `count`=0. LIFO contents are don't-care.
- **COLLECT**, on `rx_dv`=1:
  - If `USE_TERM`=1 and `rx_byte`==TERMINATOR:
    - `count`>0 → go to SEND. The terminator is neither stored nor echoed.
    - `count`==0 → ignore the byte; no drop pulse.
  - Otherwise: write `buf[count]`=`rx_byte`, then `count`++. If the new `count`==DEPTH → go to SEND.
- **SEND**: if `tx_active`=0 → `tx_byte`<=`buf[count-1]`, `tx_dv`<=1, `count`--, go to WAIT. If `tx_active`=1 → stay in SEND; `tx_dv` stays 0.
- **WAIT**: `tx_dv` returns to 0 the cycle after it was asserted. On `tx_done`=1:
  - `count`==0 → go to COLLECT.
  - else → go to SEND.
- `rx_dv`=1 while in SEND or WAIT: the byte is discarded, `rx_drop`=1 for one cycle, `count` and the LIFO are unchanged.
- `tx_done` seen outside WAIT is ignored.
- Bytes are transmitted in reverse arrival order. `count` never exceeds DEPTH and never wraps below 0.
- `tx_byte` holds its value from the cycle `tx_dv` rises until the next load. It is never changed while `tx_active`=1.

## Timing
- `rx_dv` sampled at edge k completes a message → state=SEND after edge k. `tx_dv`=1 during the cycle after edge k+1 when `tx_active`=0.
- `tx_done` sampled at edge m with `count`>0 → SEND after edge m → next `tx_dv` pulse after edge m+1. This gives a 2-cycle gap from Done to the next DV.
- `tx_dv` is high for exactly one cycle per byte.
- Exactly `count` DV pulses are issued per drain.
- `busy` rises on the edge that enters SEND. It falls on the edge that returns to COLLECT.
- `rx_dv` and `tx_done` in the same cycle while in WAIT: the byte is dropped and the Done is processed normally.
- Reset asserted mid-drain: outputs go to reset values immediately and asynchronously. Remaining bytes are lost. After release, the first `rx_dv` is stored at `buf[0]`.

## Test plan
- DEPTH=4, USE_TERM=0: rx 'A','B','C','D' with the uart_tx model → tx sequence 'D','C','B','A'; 4 DV pulses; `busy` falls after the 4th Done; `count`=0.
- USE_TERM=1: rx 'x','y',8'h0D → tx 'y','x' only; 8'h0D never transmitted.
- USE_TERM=1: lone 8'h0D with `count`=0 → no DV, `busy`=0, `rx_drop`=0.
- During drain of 'A','B','C','D': inject rx 'Z' in WAIT → `rx_drop` pulses once; tx still 'D','C','B','A'; 'Z' never echoed; `count`=0 at end.
- Hold `tx_active`=1 for 50 cycles on entering SEND → no `tx_dv` until `tx_active` falls, then DV one cycle later with `tx_byte`=last stored byte.
- Assert `rst_n`=0 in WAIT after 2 of 4 bytes are sent → `tx_dv`=0, `count`=0, `busy`=0 immediately. After release, rx 'Q','R','S','T' → tx 'T','S','R','Q'.
